// File: rtl/ara_pkg.sv
// Shared types, constant tables and segmented-arithmetic helpers for the Ara lane SIMD divider.
package ara_pkg;

    typedef logic [63:0] elen_t;

    typedef enum logic [1:0] {
        EW8  = 2'd0,
        EW16 = 2'd1,
        EW32 = 2'd2,
        EW64 = 2'd3
    } vew_e;

    typedef enum logic [2:0] {
        VDIVU = 3'd0,
        VDIV  = 3'd1,
        VREMU = 3'd2,
        VREM  = 3'd3,
        VMUL  = 3'd4,
        VMULH = 3'd5
    } ara_op_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        FIX,
        DONE
    } simd_div_state_e;

    typedef struct packed {
        logic valid;
        logic is_signed;
        logic sel_quot;
    } div_op_info_t;

    // Element width per vew, plus which bytes open and close an element.
    localparam logic [6:0] ELEM_WIDTH [4] = '{7'd8, 7'd16, 7'd32, 7'd64};
    localparam logic [7:0] FIRST_BYTE [4] = '{8'hFF, 8'h55, 8'h11, 8'h01};
    localparam logic [7:0] LAST_BYTE  [4] = '{8'hFF, 8'hAA, 8'h88, 8'h80};

    function automatic div_op_info_t div_op_info(input ara_op_e op);
        div_op_info_t info;
        info = '0;
        case (op)
            VDIVU:   info = '{valid: 1'b1, is_signed: 1'b0, sel_quot: 1'b1};
            VDIV:    info = '{valid: 1'b1, is_signed: 1'b1, sel_quot: 1'b1};
            VREMU:   info = '{valid: 1'b1, is_signed: 1'b0, sel_quot: 1'b0};
            VREM:    info = '{valid: 1'b1, is_signed: 1'b1, sel_quot: 1'b0};
            default: info = '0;
        endcase
        return info;
    endfunction

    function automatic elen_t byte_expand(input logic [7:0] m);
        elen_t res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            res[8*i +: 8] = {8{m[i]}};
        end
        return res;
    endfunction

    function automatic elen_t byte_mux(input logic [7:0] sel, input elen_t x, input elen_t y);
        elen_t e;
        e = byte_expand(sel);
        return (e & x) | (~e & y);
    endfunction

    // Two's complement negate with the carry chain restarted at every element.
    function automatic elen_t seg_neg(input elen_t x, input logic [7:0] first);
        elen_t      res;
        logic [8:0] sum;
        logic       carry;
        res   = '0;
        carry = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (first[i]) carry = 1'b1;
            sum = {1'b0, ~x[8*i +: 8]} + {8'd0, carry};
            res[8*i +: 8] = sum[7:0];
            carry = sum[8];
        end
        return res;
    endfunction

    // AND of per-byte flags over each element, broadcast back to every byte of it.
    function automatic logic [7:0] elem_and(input logic [7:0] f, input logic [7:0] first,
                                            input logic [7:0] last);
        logic [7:0] acc;
        logic [7:0] res;
        logic       run;
        acc = '0;
        res = '0;
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (first[i]) run = 1'b1;
            run    = run & f[i];
            acc[i] = run;
        end
        run = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (last[i]) run = acc[i];
            res[i] = run;
        end
        return res;
    endfunction

endpackage

// File: rtl/simd_div_step.sv
// One restoring division step over a packed 64-bit word; shifts and borrows never
// cross the element boundaries selected by vew.
module simd_div_step
    import ara_pkg::*;
(
    input  vew_e        vew,
    input  logic [63:0] rem,
    input  logic [63:0] dvd,
    input  logic [63:0] dvs,
    output logic [63:0] rem_next,
    output logic [63:0] dvd_next
);

    logic [7:0]  first;
    logic [7:0]  last;
    logic [6:0]  width;
    logic [63:0] lsb_mask;
    logic [63:0] msb_mask;
    logic [63:0] rem_sh;
    logic [63:0] diff;
    logic [63:0] take_w;
    logic [7:0]  no_borrow;
    logic [7:0]  take;
    logic [8:0]  sum;
    logic        carry;
    logic        cur;

    assign first = FIRST_BYTE[vew];
    assign last  = LAST_BYTE[vew];
    assign width = ELEM_WIDTH[vew];

    always_comb begin
        lsb_mask = '0;
        msb_mask = '0;
        for (int i = 0; i < 8; i++) begin
            lsb_mask[8*i]     = first[i];
            msb_mask[8*i + 7] = last[i];
        end
    end

    // Each element's dividend MSB lands on that same element's LSB after the right shift.
    assign rem_sh = ({rem[62:0], 1'b0} & ~lsb_mask) | ((dvd & msb_mask) >> (width - 7'd1));

    always_comb begin
        diff      = '0;
        no_borrow = '0;
        sum       = '0;
        carry     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (first[i]) carry = 1'b1;
            sum = {1'b0, rem_sh[8*i +: 8]} + {1'b0, ~dvs[8*i +: 8]} + {8'd0, carry};
            diff[8*i +: 8] = sum[7:0];
            carry          = sum[8];
            no_borrow[i]   = sum[8];
        end
    end

    // The bit shifted out of the element MSB is the hidden W+1'th remainder bit.
    always_comb begin
        take = '0;
        cur  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (last[i]) cur = no_borrow[i] | rem[8*i + 7];
            take[i] = cur;
        end
    end

    assign take_w   = byte_expand(take);
    assign rem_next = (take_w & diff) | (~take_w & rem_sh);
    assign dvd_next = ({dvd[62:0], 1'b0} & ~lsb_mask) | (lsb_mask & take_w);

endmodule

// File: rtl/simd_div.sv
// Iterative SIMD integer divider (vdiv/vdivu/vrem/vremu) on one packed 64-bit word.
// Optional: define SIMD_DIV_ZERO_BYPASS_EN to skip the iterations when every divisor is zero.
module simd_div
    import ara_pkg::*;
#(
    parameter int NumLanes8 = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [63:0]          operand_a_i,
    input  logic [63:0]          operand_b_i,
    input  logic [NumLanes8-1:0] mask_i,
    input  ara_op_e              op_i,
    input  vew_e                 vew_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [63:0]          result_o,
    output logic [NumLanes8-1:0] mask_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    simd_div_state_e state_q, state_d;

    logic [63:0]          a_q, b_q, dvd_q, dvs_q, rem_q, result_q;
    logic [NumLanes8-1:0] mask_q;
    logic [7:0]           zero_q, ovf_q, qneg_q, rneg_q;
    ara_op_e              op_q;
    vew_e                 vew_q;
    logic [5:0]           cnt_q;

    div_op_info_t info;
    logic [7:0]   first, last;
    logic [7:0]   fbz, fa, fb, sa_raw, sb_raw;
    logic [7:0]   zero_b, sign_a, sign_b, ovf_b;
    logic [63:0]  abs_a, abs_b, rem_next, dvd_next;
    logic [63:0]  q_fix, r_fix, fix_result;
    logic [6:0]   width_m1;

    assign info     = div_op_info(op_q);
    assign first    = FIRST_BYTE[vew_q];
    assign last     = LAST_BYTE[vew_q];
    assign width_m1 = ELEM_WIDTH[vew_q] - 7'd1;

    // Per-byte raw flags; elem_and folds them into per-element flags.
    always_comb begin
        fbz    = '0;
        fa     = '0;
        fb     = '0;
        sa_raw = '0;
        sb_raw = '0;
        for (int i = 0; i < 8; i++) begin
            fbz[i]    = (b_q[8*i +: 8] == 8'h00);
            fa[i]     = last[i] ? (a_q[8*i +: 8] == 8'h80) : (a_q[8*i +: 8] == 8'h00);
            fb[i]     = (b_q[8*i +: 8] == 8'hFF);
            sa_raw[i] = last[i] ? a_q[8*i + 7] : 1'b1;
            sb_raw[i] = last[i] ? b_q[8*i + 7] : 1'b1;
        end
    end

    assign zero_b = elem_and(fbz, first, last);
    assign sign_a = elem_and(sa_raw, first, last) & {8{info.is_signed}};
    assign sign_b = elem_and(sb_raw, first, last) & {8{info.is_signed}};
    assign ovf_b  = elem_and(fa, first, last) & elem_and(fb, first, last) & {8{info.is_signed}};
    assign abs_a  = byte_mux(sign_a, seg_neg(a_q, first), a_q);
    assign abs_b  = byte_mux(sign_b, seg_neg(b_q, first), b_q);

    simd_div_step u_step (
        .vew      (vew_q),
        .rem      (rem_q),
        .dvd      (dvd_q),
        .dvs      (dvs_q),
        .rem_next (rem_next),
        .dvd_next (dvd_next)
    );

    // Sign fix-up first, then the divide-by-zero and overflow overrides.
    always_comb begin
        q_fix = byte_mux(qneg_q, seg_neg(dvd_q, first), dvd_q);
        q_fix = byte_mux(zero_q, '1, q_fix);
        q_fix = byte_mux(ovf_q, a_q, q_fix);
        r_fix = byte_mux(rneg_q, seg_neg(rem_q, first), rem_q);
        r_fix = byte_mux(zero_q, a_q, r_fix);
        r_fix = byte_mux(ovf_q, '0, r_fix);
        fix_result = '0;
        if (info.valid) fix_result = info.sel_quot ? q_fix : r_fix;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = ~rst_i;
                if (valid_i) state_d = PREP;
            end
            PREP: begin
                state_d = DIV;
`ifdef SIMD_DIV_ZERO_BYPASS_EN
                if (&zero_b) state_d = FIX;
`endif
            end
            DIV:  if (cnt_q == 6'd0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
            mask_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (valid_i) begin
                    a_q    <= operand_a_i;
                    b_q    <= operand_b_i;
                    op_q   <= op_i;
                    vew_q  <= vew_i;
                    mask_q <= mask_i;
                end
                PREP: begin
                    dvd_q  <= abs_a;
                    dvs_q  <= abs_b;
                    rem_q  <= '0;
                    zero_q <= zero_b;
                    ovf_q  <= ovf_b;
                    qneg_q <= sign_a ^ sign_b;
                    rneg_q <= sign_a;
                    cnt_q  <= width_m1[5:0];
                end
                DIV: begin
                    rem_q <= rem_next;
                    dvd_q <= dvd_next;
                    cnt_q <= cnt_q - 6'd1;
                end
                FIX:     result_q <= fix_result;
                default: ;
            endcase
        end
    end

    assign result_o = result_q;
    assign mask_o   = mask_q;

endmodule

// File: tb/tb_simd_div.sv
// Self-checking bench for simd_div: vector table plus reference model, scoreboard queue,
// backpressure and mid-operation reset sequences.
module tb_simd_div;
    import ara_pkg::*;

    typedef struct {
        ara_op_e     op;
        vew_e        vew;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] result;
        logic [7:0]  mask;
        int          latency;
    } exp_t;

`ifdef SIMD_DIV_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
    logic [7:0]  mask_in;
    ara_op_e     op;
    vew_e        vew;
    logic        valid_in;
    logic        ready_out;
    logic [63:0] result_out;
    logic [7:0]  mask_out;
    logic        valid_out;
    logic        ready_in;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    simd_div dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .operand_a_i (operand_a),
        .operand_b_i (operand_b),
        .mask_i      (mask_in),
        .op_i        (op),
        .vew_i       (vew),
        .valid_i     (valid_in),
        .ready_o     (ready_out),
        .result_o    (result_out),
        .mask_o      (mask_out),
        .valid_o     (valid_out),
        .ready_i     (ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] elem_mask(input int w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] ref_model(input ara_op_e op_r, input vew_e vew_r,
                                              input logic [63:0] a, input logic [63:0] b);
        int          w;
        logic [63:0] m, ea, eb, val, res;
        longint      sa, sb;
        w   = 8 << int'(vew_r);
        m   = elem_mask(w);
        res = '0;
        for (int k = 0; k < 64 / w; k++) begin
            ea = (a >> (k * w)) & m;
            eb = (b >> (k * w)) & m;
            sa = longint'(ea << (64 - w)) >>> (64 - w);
            sb = longint'(eb << (64 - w)) >>> (64 - w);
            case (op_r)
                VDIVU: val = (eb == 0) ? m : ea / eb;
                VREMU: val = (eb == 0) ? ea : ea % eb;
                VDIV, VREM: begin
                    if (eb == 0)
                        val = (op_r == VDIV) ? m : ea;
                    else if (ea == (64'd1 << (w - 1)) && eb == m)
                        val = (op_r == VDIV) ? ea : 64'd0;
                    else if (op_r == VDIV)
                        val = 64'(sa / sb);
                    else
                        val = 64'(sa % sb);
                end
                default: val = '0;
            endcase
            res = res | ((val & m) << (k * w));
        end
        return res;
    endfunction

    function automatic int exp_latency(input vew_e v, input logic [63:0] b);
        int          w;
        logic        all_zero;
        logic [63:0] m;
        w        = 8 << int'(v);
        m        = elem_mask(w);
        all_zero = 1'b1;
        for (int k = 0; k < 64 / w; k++) begin
            if (((b >> (k * w)) & m) != 64'd0) all_zero = 1'b0;
        end
        if (all_zero && BYPASS) return 2;
        return w + 2;
    endfunction

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Waits for ready, drives one word for one accept edge, then scrambles the inputs.
    task automatic apply_stimulus(input ara_op_e o, input vew_e v, input logic [63:0] a,
                                  input logic [63:0] b, input logic [7:0] m,
                                  input logic [63:0] exp_res);
        int guard;
        exp_t e;
        guard = 0;
        while (!ready_out && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_output("ready_before_accept", 64'(ready_out), 64'd1);
        operand_a = a;
        operand_b = b;
        mask_in   = m;
        op        = o;
        vew       = v;
        valid_in  = 1'b1;
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        operand_a = {$urandom, $urandom};
        operand_b = {$urandom, $urandom};
        mask_in   = ~m;
        op        = VMUL;
        vew       = (v == EW8) ? EW64 : EW8;
        e.result  = exp_res;
        e.mask    = m;
        e.latency = exp_latency(v, b);
        sb_q.push_back(e);
    endtask

    task automatic wait_result(input string name);
        int   n;
        exp_t e;
        n = 0;
        while (!valid_out && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output({name, "_valid"}, 64'(valid_out), 64'd1);
        check_output({name, "_sb_depth"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_output({name, "_result"}, result_out, e.result);
            check_output({name, "_mask"}, 64'(mask_out), 64'(e.mask));
            check_output({name, "_latency"}, 64'(n), 64'(e.latency));
        end
        if (ready_in) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t        vecs[14];
        logic [63:0] ra, rb;
        ara_op_e     rop;
        vew_e        rvew;
        logic        seen;

        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        valid_in  = 1'b0;
        ready_in  = 1'b1;
        operand_a = '0;
        operand_b = '0;
        mask_in   = '0;
        op        = VDIVU;
        vew       = EW8;

        vecs[0]  = '{VDIVU, EW8,  64'h6464646464646464, 64'h0707070707070707, 64'h0E0E0E0E0E0E0E0E};
        vecs[1]  = '{VREMU, EW8,  64'h6464646464646464, 64'h0707070707070707, 64'h0202020202020202};
        vecs[2]  = '{VDIV,  EW32, 64'hFFFFFFF9FFFFFFF9, 64'h0000000200000002, 64'hFFFFFFFDFFFFFFFD};
        vecs[3]  = '{VREM,  EW32, 64'hFFFFFFF9FFFFFFF9, 64'h0000000200000002, 64'hFFFFFFFFFFFFFFFF};
        vecs[4]  = '{VDIVU, EW64, 64'h0000000000000005, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF};
        vecs[5]  = '{VREMU, EW64, 64'h0000000000000005, 64'h0000000000000000, 64'h0000000000000005};
        vecs[6]  = '{VDIV,  EW16, 64'h8000800080008000, 64'hFFFFFFFFFFFFFFFF, 64'h8000800080008000};
        vecs[7]  = '{VREM,  EW16, 64'h8000800080008000, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000};
        vecs[8]  = '{VDIV,  EW16, 64'h80000064FFF90007, 64'hFFFF000700020000, 64'h8000000EFFFDFFFF};
        vecs[9]  = '{VREM,  EW16, 64'h80000064FFF90007, 64'hFFFF000700020000, 64'h00000002FFFF0007};
        vecs[10] = '{VMUL,  EW8,  64'h6464646464646464, 64'h0707070707070707, 64'h0000000000000000};
        vecs[11] = '{VDIV,  EW8,  64'h9C9C9C9C9C9C9C9C, 64'h0707070707070707, 64'hF2F2F2F2F2F2F2F2};
        vecs[12] = '{VREM,  EW8,  64'h9C9C9C9C9C9C9C9C, 64'h0707070707070707, 64'hFEFEFEFEFEFEFEFE};
        vecs[13] = '{VDIVU, EW32, 64'h12345678FFFFFFFF, 64'h0000010000000001, 64'h00123456FFFFFFFF};

        repeat (3) @(posedge clk);
        #1;
        check_output("rst_ready", 64'(ready_out), 64'd0);
        check_output("rst_valid", 64'(valid_out), 64'd0);
        check_output("rst_result", result_out, 64'd0);
        check_output("rst_mask", 64'(mask_out), 64'd0);
        rst = 1'b0;
        #1;
        check_output("post_rst_ready", 64'(ready_out), 64'd1);

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].vew, vecs[i].a, vecs[i].b, 8'($urandom), vecs[i].exp);
            wait_result($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            rop  = ara_op_e'($urandom_range(0, 3));
            rvew = vew_e'($urandom_range(0, 3));
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom} >> $urandom_range(0, 56);
            apply_stimulus(rop, rvew, ra, rb, 8'($urandom), ref_model(rop, rvew, ra, rb));
            wait_result($sformatf("rand%0d", i));
        end

        // Backpressure: DONE holds while ready_i is low and ignores new valid_i.
        ready_in = 1'b0;
        apply_stimulus(VDIVU, EW8, 64'h6464646464646464, 64'h0707070707070707, 8'hA5,
                       64'h0E0E0E0E0E0E0E0E);
        wait_result("bp");
        valid_in  = 1'b1;
        operand_a = 64'h1111111111111111;
        operand_b = 64'h0101010101010101;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("bp_valid%0d", i), 64'(valid_out), 64'd1);
            check_output($sformatf("bp_result%0d", i), result_out, 64'h0E0E0E0E0E0E0E0E);
            check_output($sformatf("bp_mask%0d", i), 64'(mask_out), 64'hA5);
            check_output($sformatf("bp_ready%0d", i), 64'(ready_out), 64'd0);
        end
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check_output("bp_release_valid", 64'(valid_out), 64'd0);
        check_output("bp_release_ready", 64'(ready_out), 64'd1);
        @(posedge clk);
        #1;
        check_output("bp_no_accept", 64'(ready_out), 64'd1);

        // Reset in DIV cycle 20 of an EW64 word drops it without a result.
        ra = {$urandom, $urandom};
        rb = 64'h0000000000001234;
        apply_stimulus(VDIVU, EW64, ra, rb, 8'h3C, ref_model(VDIVU, EW64, ra, rb));
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("midrst_valid", 64'(valid_out), 64'd0);
        rst = 1'b0;
        #1;
        check_output("midrst_ready", 64'(ready_out), 64'd1);
        sb_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) seen = 1'b1;
        end
        check_output("midrst_no_valid", 64'(seen), 64'd0);

        ra = 64'hFFFFFFFFFFFF0001;
        rb = 64'h0000000000000003;
        apply_stimulus(VDIV, EW64, ra, rb, 8'h5A, ref_model(VDIV, EW64, ra, rb));
        wait_result("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
